// File: rtl/poly_accumulator_if.sv
// Term/result handshake bundle for poly_accumulator.
// The accumulator side uses the slave modport.
interface poly_accumulator_if #(
    parameter int WL_IN  = 16,
    parameter int WL_OUT = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [WL_IN-1:0]  in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [WL_OUT-1:0] out_data;
    logic                     out_sat;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/poly_accumulator.sv
// Sums DEGREE+1 signed terms, then rounds, shifts and clips/wraps
// the sum into a held result released by a valid/ready handshake.
module poly_accumulator #(
    parameter int WL_IN    = 16,
    parameter int DEGREE   = 3,
    parameter int WL_OUT   = 16,
    parameter int SHIFT    = 0,
    parameter int SATURATE = 1
) (
    input logic               clock,
    input logic               resetn,
    input logic               in_clear,
    poly_accumulator_if.slave port
);
    localparam int WIDENING = (DEGREE < 1) ? 1 : $clog2(DEGREE + 1);
    localparam int WL_ACC   = WL_IN + WIDENING;
    localparam int WR       = WL_ACC + 1;
    localparam int CW       = $clog2(DEGREE + 2);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } state_t;

    state_t                   state;
    state_t                   state_n;
    logic signed [WL_ACC-1:0] acc;
    logic signed [WL_ACC-1:0] sum;
    logic        [CW-1:0]     count;
    logic        [CW-1:0]     count_n;
    logic                     take;
    logic                     last;
    logic signed [WR-1:0]     wide;
    logic signed [WR-1:0]     r;
    logic        [WL_OUT-1:0] res_data;
    logic                     res_sat;
    logic        [WL_OUT-1:0] data_q;
    logic                     sat_q;

    assign port.in_ready  = (state != HOLD);
    assign port.out_valid = (state == HOLD);
    assign port.out_data  = data_q;
    assign port.out_sat   = sat_q;

    assign take = port.in_valid && port.in_ready;

    // An IDLE accept starts a fresh sum, so acc/count are ignored there.
    always_comb begin
        sum     = WL_ACC'(port.in_data);
        count_n = CW'(1);
        if (state == ACC) begin
            sum     = acc + WL_ACC'(port.in_data);
            count_n = count + CW'(1);
        end
        last = (count_n == CW'(DEGREE + 1));
    end

    assign wide = WR'(sum);

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [WR-1:0] HALF =
                {{(WR-1){1'b0}}, 1'b1} << (SHIFT - 1);
            assign r = (wide + HALF) >>> SHIFT;
        end else begin : g_noround
            assign r = wide;
        end
    endgenerate

    generate
        if (WL_OUT >= WR) begin : g_ext
            assign res_data = WL_OUT'(r);
            assign res_sat  = 1'b0;
        end else begin : g_fit
            logic [WR-WL_OUT:0] top;
            logic               fits;
            assign top  = r[WR-1:WL_OUT-1];
            assign fits = (&top) | ~(|top);
            assign res_sat = ~fits;
            always_comb begin
                res_data = r[WL_OUT-1:0];
                if (!fits && SATURATE != 0) begin
                    res_data = r[WR-1] ?
                        {1'b1, {(WL_OUT-1){1'b0}}} :
                        {1'b0, {(WL_OUT-1){1'b1}}};
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (in_clear) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE, ACC: begin
                    if (take) state_n = last ? HOLD : ACC;
                end
                HOLD: begin
                    if (port.out_ready) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn || in_clear) begin
            acc    <= '0;
            count  <= '0;
            data_q <= '0;
            sat_q  <= 1'b0;
        end else if (take) begin
            acc   <= sum;
            count <= count_n;
            if (last) begin
                data_q <= res_data;
                sat_q  <= res_sat;
            end
        end
    end
endmodule
